// File: rtl/tmds_decode.sv
`default_nettype none
// ============================================================================
// Module      : tmds_decode
// Description : Receive-side decoder for one TMDS channel. Recovers DE, the
//               two control bits and the 8-bit pixel from 10-bit symbols
//               delivered by a per-channel deserializer. Flags invalid data
//               symbols and runs a word-alignment state machine that pulses
//               bitslip back to the deserializer until it sees a steady run
//               of control tokens.
//
// Ports       : pixel_clk  in   1  pixel clock, rising edge
//               rst        in   1  synchronous active-high reset
//               tmds_data  in  10  raw symbol, bit 0 = first bit on the wire
//               bitslip    out  1  one-cycle pulse: shift word boundary by 1
//               locked     out  1  word alignment achieved
//               active     out  1  DE: current output is video data
//               ctl        out  2  {C1,C0}, held at last value during video
//               pdata      out  8  decoded pixel, 0 outside video
//               sym_err    out  1  one-cycle pulse: invalid data symbol
//
// Revision    : 1.0  initial release
// ============================================================================
module tmds_decode #(
    parameter int LOCK_CTL_COUNT = 16,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int SLIP_WAIT      = 8,
    parameter int ERR_LIMIT      = 4
) (
    input  logic       pixel_clk,
    input  logic       rst,
    input  logic [9:0] tmds_data,
    output logic       bitslip,
    output logic       locked,
    output logic       active,
    output logic [1:0] ctl,
    output logic [7:0] pdata,
    output logic       sym_err
);

    // ------------------------------------------------------------------
    // Counter widths and terminal values
    // ------------------------------------------------------------------
    localparam int c_RUN_W   = $clog2(LOCK_CTL_COUNT) + 1;
    localparam int c_TIMER_W = $clog2(SEARCH_TIMEOUT) + 1;
    localparam int c_SLIP_W  = $clog2(SLIP_WAIT) + 1;
    localparam int c_ERR_W   = $clog2(ERR_LIMIT) + 1;

    // Transitions fire on the edge where a counter would reach its limit,
    // so the comparisons are against limit-1 on the current value.
    localparam logic [c_RUN_W-1:0]   c_RUN_LAST   = c_RUN_W'(LOCK_CTL_COUNT - 1);
    localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(SEARCH_TIMEOUT - 1);
    localparam logic [c_SLIP_W-1:0]  c_SLIP_LAST  = c_SLIP_W'(SLIP_WAIT - 1);
    localparam logic [c_ERR_W-1:0]   c_ERR_MAX    = c_ERR_W'(ERR_LIMIT);

    // Control token encodings
    localparam logic [9:0] c_TOK_00 = 10'h354;
    localparam logic [9:0] c_TOK_01 = 10'h0AB;
    localparam logic [9:0] c_TOK_10 = 10'h154;
    localparam logic [9:0] c_TOK_11 = 10'h2AB;

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_SLIP   = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Stage 1: register the raw symbol and classify it
    // ------------------------------------------------------------------
    logic       w_in_is_ctl;
    logic [1:0] w_in_ctl_val;

    always_comb begin
        w_in_is_ctl  = 1'b1;
        w_in_ctl_val = 2'b00;
        case (tmds_data)
            c_TOK_00: w_in_ctl_val = 2'b00;
            c_TOK_01: w_in_ctl_val = 2'b01;
            c_TOK_10: w_in_ctl_val = 2'b10;
            c_TOK_11: w_in_ctl_val = 2'b11;
            default:  w_in_is_ctl  = 1'b0;
        endcase
    end

    logic [9:0] r_q;
    logic       r_is_ctl;
    logic [1:0] r_ctl_val;

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_q       <= '0;
            r_is_ctl  <= 1'b0;
            r_ctl_val <= 2'b00;
        end else begin
            r_q       <= tmds_data;
            r_is_ctl  <= w_in_is_ctl;
            r_ctl_val <= w_in_ctl_val;
        end
    end

    // ------------------------------------------------------------------
    // Data decode and validity of the stage-1 symbol
    // ------------------------------------------------------------------
    logic [7:0] w_d;
    logic [7:0] w_pix;
    logic [3:0] w_ones;
    logic       w_exp8;
    logic       w_err;

    always_comb begin
        // Bit 9 marks an inverted payload
        w_d      = r_q[9] ? ~r_q[7:0] : r_q[7:0];
        w_pix    = '0;
        w_pix[0] = w_d[0];
        // Bit 8 selects between the XOR and XNOR transition chains
        for (int i = 1; i < 8; i++) begin
            w_pix[i] = r_q[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
        end
    end

    always_comb begin
        w_ones = '0;
        for (int i = 0; i < 8; i++) begin
            w_ones = w_ones + 4'(w_pix[i]);
        end
        // A legal encoder would have picked XNOR (bit 8 = 0) exactly when
        // the pixel is ones-heavy, ties broken by bit 0 being 0.
        w_exp8 = !((w_ones > 4'd4) || ((w_ones == 4'd4) && !w_pix[0]));
    end

    assign w_err = locked && !r_is_ctl && (r_q[8] != w_exp8);

    // ------------------------------------------------------------------
    // Stage 2: output register
    // ------------------------------------------------------------------
    logic       r_active;
    logic [1:0] r_ctl;
    logic [7:0] r_pdata;
    logic       r_sym_err;

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_active  <= 1'b0;
            r_ctl     <= 2'b00;
            r_pdata   <= '0;
            r_sym_err <= 1'b0;
        end else if (!locked) begin
            // Unaligned symbols carry no meaning: present an idle channel
            r_active  <= 1'b0;
            r_ctl     <= 2'b00;
            r_pdata   <= '0;
            r_sym_err <= 1'b0;
        end else if (r_is_ctl) begin
            r_active  <= 1'b0;
            r_ctl     <= r_ctl_val;
            r_pdata   <= '0;
            r_sym_err <= 1'b0;
        end else begin
            // ctl keeps its last value through the video period; the pixel
            // is still delivered when the symbol is flagged invalid.
            r_active  <= 1'b1;
            r_pdata   <= w_pix;
            r_sym_err <= w_err;
        end
    end

    assign active  = r_active;
    assign ctl     = r_ctl;
    assign pdata   = r_pdata;
    assign sym_err = r_sym_err;

    // ------------------------------------------------------------------
    // Word-alignment FSM (driven by stage-1 flags)
    // ------------------------------------------------------------------
    state_t                 r_state,   w_state_nxt;
    logic [c_RUN_W-1:0]     r_run,     w_run_nxt;
    logic [c_TIMER_W-1:0]   r_timer,   w_timer_nxt;
    logic [c_SLIP_W-1:0]    r_slip,    w_slip_nxt;
    logic [c_ERR_W-1:0]     r_err,     w_err_nxt;
    logic                   r_bitslip, w_bitslip_nxt;

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_state   <= S_SEARCH;
            r_run     <= '0;
            r_timer   <= '0;
            r_slip    <= '0;
            r_err     <= '0;
            r_bitslip <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_run     <= w_run_nxt;
            r_timer   <= w_timer_nxt;
            r_slip    <= w_slip_nxt;
            r_err     <= w_err_nxt;
            r_bitslip <= w_bitslip_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_run_nxt     = r_run;
        w_timer_nxt   = r_timer;
        w_slip_nxt    = r_slip;
        w_err_nxt     = r_err;
        w_bitslip_nxt = 1'b0;

        case (r_state)
            S_SEARCH: begin
                w_run_nxt   = r_is_ctl ? r_run + 1'b1 : '0;
                w_timer_nxt = r_timer + 1'b1;
                // Lock is checked first so it wins over a coincident timeout
                if (r_is_ctl && (r_run == c_RUN_LAST)) begin
                    w_state_nxt = S_LOCKED;
                    w_run_nxt   = '0;
                    w_timer_nxt = '0;
                    w_err_nxt   = '0;
                end else if (r_timer == c_TIMER_LAST) begin
                    w_state_nxt   = S_SLIP;
                    w_bitslip_nxt = 1'b1;
                    w_run_nxt     = '0;
                    w_timer_nxt   = '0;
                    w_slip_nxt    = '0;
                end
            end

            S_SLIP: begin
                // Input is ignored while the deserializer settles
                w_slip_nxt = r_slip + 1'b1;
                if (r_slip == c_SLIP_LAST) begin
                    w_state_nxt = S_SEARCH;
                    w_slip_nxt  = '0;
                end
            end

            S_LOCKED: begin
                if (r_is_ctl) begin
                    w_err_nxt   = '0;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                    if (w_err && (r_err != c_ERR_MAX)) begin
                        w_err_nxt = r_err + 1'b1;
                    end
                    // Losing lock goes straight back to searching; the
                    // current boundary may still be right, so no bitslip.
                    if ((w_err_nxt == c_ERR_MAX) || (r_timer == c_TIMER_LAST)) begin
                        w_state_nxt = S_SEARCH;
                        w_run_nxt   = '0;
                        w_timer_nxt = '0;
                        w_slip_nxt  = '0;
                        w_err_nxt   = '0;
                    end
                end
            end

            default: begin
                w_state_nxt = S_SEARCH;
                w_run_nxt   = '0;
                w_timer_nxt = '0;
                w_slip_nxt  = '0;
                w_err_nxt   = '0;
            end
        endcase
    end

    assign bitslip = r_bitslip;
    assign locked  = (r_state == S_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_tmds_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_tmds_decode
// Description : Directed self-checking bench for tmds_decode. Each driven
//               symbol pushes its expected output onto a scoreboard queue;
//               entries are popped and compared two cycles later. Expected
//               pixels come from searching the TMDS encoder forward.
// Revision    : 1.0  initial release
// ============================================================================
module tb_tmds_decode;

    localparam int M_IDLE = 0;
    localparam int M_CTL  = 1;
    localparam int M_DATA = 2;

    logic       pixel_clk = 1'b0;
    logic       rst;
    logic [9:0] tmds_data;
    logic       bitslip;
    logic       locked;
    logic       active;
    logic [1:0] ctl;
    logic [7:0] pdata;
    logic       sym_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [9:0] sym;
        int         mode;
        logic [1:0] ctl;
    } sb_t;

    sb_t sb[$];

    tmds_decode #(
        .LOCK_CTL_COUNT (16),
        .SEARCH_TIMEOUT (64),
        .SLIP_WAIT      (8),
        .ERR_LIMIT      (4)
    ) dut (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .tmds_data (tmds_data),
        .bitslip   (bitslip),
        .locked    (locked),
        .active    (active),
        .ctl       (ctl),
        .pdata     (pdata),
        .sym_err   (sym_err)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Find the pixel whose encoding (with the symbol's own bit 8/bit 9
    // choices) produces sym, and judge whether bit 8 is the legal choice.
    task automatic ref_decode(input logic [9:0] sym, output logic [7:0] pix, output logic valid);
        logic [7:0] pv;
        logic [7:0] qm;
        logic [9:0] enc;
        int         ones;
        logic       use_xnor;
        pix = '0;
        for (int p = 0; p < 256; p++) begin
            pv    = 8'(p);
            qm[0] = pv[0];
            for (int i = 1; i < 8; i++) begin
                qm[i] = sym[8] ? (qm[i-1] ^ pv[i]) : ~(qm[i-1] ^ pv[i]);
            end
            enc = {sym[9], sym[8], (sym[9] ? ~qm : qm)};
            if (enc == sym) pix = pv;
        end
        ones     = $countones(pix);
        use_xnor = (ones > 4) || ((ones == 4) && (pix[0] == 1'b0));
        valid    = (sym[8] == !use_xnor);
    endtask

    task automatic compare(input sb_t e);
        logic [7:0] pix;
        logic       valid;
        case (e.mode)
            M_DATA: begin
                ref_decode(e.sym, pix, valid);
                chk("data_active", active, 1);
                chk("data_pdata", pdata, pix);
                chk("data_sym_err", sym_err, !valid);
                chk("data_ctl_hold", ctl, e.ctl);
            end
            M_CTL: begin
                chk("ctl_active", active, 0);
                chk("ctl_value", ctl, e.ctl);
                chk("ctl_pdata", pdata, 0);
                chk("ctl_sym_err", sym_err, 0);
            end
            default: begin
                chk("idle_active", active, 0);
                chk("idle_ctl", ctl, 0);
                chk("idle_pdata", pdata, 0);
                chk("idle_sym_err", sym_err, 0);
            end
        endcase
    endtask

    // One clock: drive a symbol, record its expectation, and retire the
    // entry whose result appears at this edge (two symbols back).
    task automatic tick(input logic [9:0] sym, input int mode, input logic [1:0] ectl);
        sb_t e;
        tmds_data = sym;
        e.sym  = sym;
        e.mode = mode;
        e.ctl  = ectl;
        sb.push_back(e);
        @(posedge pixel_clk);
        #1;
        if (sb.size() >= 2) begin
            e = sb.pop_front();
            compare(e);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst       = 1'b1;
        tmds_data = 10'h000;
        repeat (cycles) @(posedge pixel_clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic relock(input string tag);
        for (int k = 1; k <= 18; k++) begin
            tick(10'h354, M_CTL, 2'b00);
            chk({tag, "_bitslip"}, bitslip, 0);
            if (k == 16) chk({tag, "_not_yet_locked"}, locked, 0);
            if (k == 17) chk({tag, "_locked"}, locked, 1);
        end
    endtask

    initial begin
        logic [9:0] rsym;

        // Reset state
        rst       = 1'b1;
        tmds_data = 10'h000;
        repeat (3) @(posedge pixel_clk);
        #1;
        chk("rst_locked", locked, 0);
        chk("rst_bitslip", bitslip, 0);
        chk("rst_active", active, 0);
        chk("rst_ctl", ctl, 0);
        chk("rst_pdata", pdata, 0);
        chk("rst_sym_err", sym_err, 0);
        rst = 1'b0;
        sb.delete();

        // Initial lock on 0x354 tokens
        for (int k = 1; k <= 20; k++) begin
            tick(10'h354, M_CTL, 2'b00);
            chk("t1_bitslip", bitslip, 0);
            if (k == 16) chk("t1_not_yet_locked", locked, 0);
            if (k == 17) chk("t1_locked", locked, 1);
        end

        // Video data, then a control token; ctl holds through video
        tick(10'h100, M_DATA, 2'b00);
        tick(10'h200, M_DATA, 2'b00);
        tick(10'h154, M_CTL,  2'b10);
        // Invalid data symbol: pixel 0x01 with sym_err, lock retained
        tick(10'h055, M_DATA, 2'b10);
        tick(10'h354, M_CTL,  2'b00);
        tick(10'h354, M_CTL,  2'b00);
        chk("t3_still_locked", locked, 1);

        // Assorted data symbols, each followed by a token
        for (int r = 0; r < 8; r++) begin
            rsym = 10'($urandom_range(0, 1023));
            while (rsym == 10'h354 || rsym == 10'h0AB || rsym == 10'h154 || rsym == 10'h2AB)
                rsym = 10'($urandom_range(0, 1023));
            tick(rsym, M_DATA, 2'b00);
            tick(10'h354, M_CTL, 2'b00);
        end
        tick(10'h354, M_CTL, 2'b00);
        chk("rand_still_locked", locked, 1);

        // Four errors without a token drop lock on the fourth
        for (int k = 1; k <= 4; k++) begin
            tick(10'h055, M_DATA, 2'b00);
            chk("t5_locked_before_limit", locked, 1);
        end
        relock("t5");

        // Reset in the middle of video
        tick(10'h2AB, M_CTL,  2'b11);
        tick(10'h100, M_DATA, 2'b11);
        tick(10'h100, M_DATA, 2'b11);
        chk("t6_active_before_rst", active, 1);
        rst       = 1'b1;
        tmds_data = 10'h100;
        @(posedge pixel_clk);
        #1;
        chk("t6_locked", locked, 0);
        chk("t6_active", active, 0);
        chk("t6_pdata", pdata, 0);
        chk("t6_ctl", ctl, 0);
        chk("t6_sym_err", sym_err, 0);
        chk("t6_bitslip", bitslip, 0);
        rst = 1'b0;
        sb.delete();
        relock("t6");

        // Misaligned stream: bitslip every SEARCH_TIMEOUT+SLIP_WAIT cycles
        do_reset(2);
        for (int n = 1; n <= 150; n++) begin
            tick(10'h29A, M_IDLE, 2'b00);
            chk("t4_bitslip", bitslip, (n == 64 || n == 136) ? 1 : 0);
            chk("t4_locked", locked, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
